lfsr_decrypt_ctrl: RTL

- Self-contained controller that decrypts a message held in the shared data memory.
- The message was encrypted by XOR with an unknown maximal-length LFSR sequence.
- Runs NPAT candidate LFSRs in parallel against a known preamble to identify the tap pattern, then decrypts the whole message from SRC_BASE into DST_BASE.
- Parametrised successor to the fixed 6-bit / 6-pattern lab top level: adds a start/done handshake, mismatch and ambiguity detection, and generic width, depth and pattern count.

---
 rtl/lfsr_decrypt_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/lfsr_decrypt_ctrl.sv
// LFSR stream-cipher breaker: identifies the tap pattern from a known preamble,
// then decrypts the message from SRC_BASE into DST_BASE.
module lfsr_decrypt_ctrl #(
  parameter int unsigned W        = 6,
  parameter int unsigned NPAT     = 6,
  parameter logic [NPAT*W-1:0] TAPS =
    {6'h39, 6'h36, 6'h33, 6'h30, 6'h2D, 6'h21},
  parameter int unsigned PRE_LEN  = 7,
  parameter logic [7:0]  PRE_CHAR = 8'h5F,
  parameter int unsigned MSG_LEN  = 64,
  parameter int unsigned AW       = 8,
  parameter int unsigned SRC_BASE = 64,
  parameter int unsigned DST_BASE = 0,
  localparam int unsigned IW = (NPAT > 1) ? $clog2(NPAT) : 1
) (
  input  logic          clk,
  input  logic          init,
  input  logic          start,
  output logic [AW-1:0] mem_raddr,
  input  logic [7:0]    mem_rdata,
  output logic [AW-1:0] mem_waddr,
  output logic [7:0]    mem_wdata,
  output logic          mem_wr_en,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          amb,
  output logic [IW-1:0] found_idx
);

  localparam int unsigned CW = $clog2(MSG_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DECIDE,
    S_DEC,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic [W-1:0]    s_q [NPAT];
  logic [W-1:0]    s_d [NPAT];
  logic [NPAT-1:0] alive_q, alive_d;
  logic [W-1:0]    k0_q, k0_d;
  logic [W-1:0]    dstate_q, dstate_d;
  logic [W-1:0]    dtap_q, dtap_d;
  logic            err_q, err_d;
  logic            amb_q, amb_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic [W-1:0]    kin;
  logic [W-1:0]    nxt [NPAT];
  logic            any_alive;
  logic            multi_alive;
  logic [IW-1:0]   sel_idx;
  logic [W-1:0]    sel_tap;
  logic            wr_c;

  // Key symbol implied by the returned byte if it carries the preamble.
  assign kin = mem_rdata[W-1:0] ^ PRE_CHAR[W-1:0];

  always_comb begin
    for (int i = 0; i < NPAT; i++) begin
      nxt[i] = {s_q[i][W-2:0], ^(s_q[i] & TAPS[i*W +: W])};
    end
  end

  // Descending scan so the lowest surviving index wins.
  always_comb begin
    any_alive   = 1'b0;
    multi_alive = 1'b0;
    sel_idx     = '0;
    sel_tap     = TAPS[W-1:0];
    for (int i = NPAT - 1; i >= 0; i--) begin
      if (alive_q[i]) begin
        multi_alive = multi_alive | any_alive;
        any_alive   = 1'b1;
        sel_idx     = IW'(i);
        sel_tap     = TAPS[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    raddr_d   = raddr_q;
    s_d       = s_q;
    alive_d   = alive_q;
    k0_d      = k0_q;
    dstate_d  = dstate_q;
    dtap_d    = dtap_q;
    err_d     = err_q;
    amb_d     = amb_q;
    idx_d     = idx_q;
    wr_c      = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PRE;
          cnt_d   = '0;
          raddr_d = AW'(SRC_BASE);
          err_d   = 1'b0;
          amb_d   = 1'b0;
          idx_d   = '0;
        end
      end
      S_PRE: begin
        cnt_d   = cnt_q + CW'(1);
        raddr_d = raddr_q + AW'(1);
        if (cnt_q == CW'(1)) begin
          for (int i = 0; i < NPAT; i++) s_d[i] = kin;
          alive_d = '1;
          k0_d    = kin;
        end else if (cnt_q >= CW'(2)) begin
          for (int i = 0; i < NPAT; i++) begin
            s_d[i] = nxt[i];
            if (nxt[i] != kin) alive_d[i] = 1'b0;
          end
        end
        if (cnt_q == CW'(PRE_LEN)) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        cnt_d   = '0;
        raddr_d = AW'(SRC_BASE);
        if (!any_alive) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d    = sel_idx;
          amb_d    = multi_alive;
          dstate_d = k0_q;
          dtap_d   = sel_tap;
          state_d  = S_DEC;
        end
      end
      S_DEC: begin
        cnt_d   = cnt_q + CW'(1);
        raddr_d = raddr_q + AW'(1);
        if (cnt_q != '0) begin
          wr_c      = 1'b1;
          mem_waddr = AW'(DST_BASE) + AW'(cnt_q) - AW'(1);
          mem_wdata = mem_rdata ^ 8'(dstate_q);
          dstate_d  = {dstate_q[W-2:0], ^(dstate_q & dtap_q)};
        end
        if (cnt_q == CW'(MSG_LEN)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      raddr_q  <= '0;
      alive_q  <= '0;
      k0_q     <= '0;
      dstate_q <= '0;
      dtap_q   <= '0;
      err_q    <= 1'b0;
      amb_q    <= 1'b0;
      idx_q    <= '0;
      for (int i = 0; i < NPAT; i++) s_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      raddr_q  <= raddr_d;
      s_q      <= s_d;
      alive_q  <= alive_d;
      k0_q     <= k0_d;
      dstate_q <= dstate_d;
      dtap_q   <= dtap_d;
      err_q    <= err_d;
      amb_q    <= amb_d;
      idx_q    <= idx_d;
    end
  end

  // An aborting init must never let a half-finished write through.
  assign mem_wr_en = wr_c & ~init;
  assign mem_raddr = raddr_q;
  assign busy      = (state_q == S_PRE) || (state_q == S_DECIDE) ||
                     (state_q == S_DEC);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign amb       = amb_q;
  assign found_idx = idx_q;

endmodule
